// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory/writeback boundary of the MIPS core.
// Holds the datapath widths, the memory-op encodings carried on MemCtrl,
// the all-zero word, and the layout of the writeback pipeline register.
// Every other file in this slice imports this package; nothing here is
// duplicated elsewhere.
package mem_wb_stage_pkg;

  localparam int DATALENGTH = 32;
  localparam int ADDRLENGTH = 32;

  // Memory-op encodings. MEM_NONE marks instructions that do not touch memory.
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [DATALENGTH-1:0] ZeroWord = '0;

  // Writeback pipeline register contents.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [3:0]            mem_ctrl;
    logic [DATALENGTH-1:0] alu;
    logic [4:0]            write_reg;
    logic [ADDRLENGTH-1:0] pc;
  } wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational lane extraction for loads.
// Picks the addressed byte / halfword / word out of a little-endian 32-bit
// SRAM word and sign- or zero-extends it.
// Ports:
//   mem_ctrl  in  4   memory-op encoding
//   addr      in  2   low address bits of the effective address
//   word      in  32  raw read word
//   extracted out 32  aligned, extended load value (ZeroWord if misaligned / not a load)
//   misalign  out 1   access is misaligned for its size
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [3:0]            mem_ctrl,
  input  logic [1:0]            addr,
  input  logic [DATALENGTH-1:0] word,
  output logic [DATALENGTH-1:0] extracted,
  output logic                  misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // addr[0] is checked separately for halfwords, so only addr[1] picks the lane.
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    extracted = ZeroWord;
    misalign  = 1'b0;
    case (mem_ctrl)
      MEM_LB:  extracted = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: extracted = {24'd0, byte_sel};
      MEM_LH: begin
        if (addr[0]) misalign = 1'b1;
        else         extracted = {{16{half_sel[15]}}, half_sel};
      end
      MEM_LHU: begin
        if (addr[0]) misalign = 1'b1;
        else         extracted = {16'd0, half_sel};
      end
      MEM_LW: begin
        if (addr != 2'd0) misalign = 1'b1;
        else              extracted = word;
      end
      default: extracted = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: pipeline stage between memory access and register-file write.
// Registers memory-stage control/address state, captures the synchronous SRAM
// read word (valid one cycle after the address), aligns and extends load data,
// and drives the writeback result. A hold buffer keeps the SRAM word stable
// while writeback is stalled so a stalled load never sees a younger access.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   stallW, flushW       hold / bubble the writeback register (flush wins)
//   validM .. pcM        memory-stage instruction state
//   data_sram_rdata      SRAM read word for the instruction now in writeback
//   validW, RegWriteW    writeback valid and gated register-file write enable
//   WriteRegW, ResultW   destination register and write data
//   pcW                  writeback PC for debug trace
//   misalignW            writeback load is misaligned; its write is suppressed
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stallW,
  input  logic                  flushW,
  input  logic                  validM,
  input  logic                  RegWriteM,
  input  logic                  MemToRegM,
  input  logic [3:0]            MemCtrlM,
  input  logic [DATALENGTH-1:0] aluM,
  input  logic [4:0]            WriteRegM,
  input  logic [ADDRLENGTH-1:0] pcM,
  input  logic [DATALENGTH-1:0] data_sram_rdata,
  output logic                  validW,
  output logic                  RegWriteW,
  output logic [4:0]            WriteRegW,
  output logic [DATALENGTH-1:0] ResultW,
  output logic [ADDRLENGTH-1:0] pcW,
  output logic                  misalignW
);

  wb_reg_t               wb_d, wb_q;
  logic                  hold_valid_d, hold_valid_q;
  logic [DATALENGTH-1:0] hold_data_d, hold_data_q;
  logic [DATALENGTH-1:0] load_word;
  logic [DATALENGTH-1:0] extracted;
  logic                  misalign;

  always_comb begin
    wb_d = wb_q;
    if (flushW) begin
      wb_d = '0;
    end else if (!stallW) begin
      wb_d.valid      = validM;
      wb_d.reg_write  = RegWriteM;
      wb_d.mem_to_reg = MemToRegM;
      wb_d.mem_ctrl   = MemCtrlM;
      wb_d.alu        = aluM;
      wb_d.write_reg  = WriteRegM;
      wb_d.pc         = pcM;
    end
  end

  // The SRAM word is only guaranteed in the first cycle the load sits in
  // writeback; capture it then and keep it for the rest of the stall.
  always_comb begin
    hold_valid_d = 1'b0;
    hold_data_d  = hold_data_q;
    if (stallW && !flushW) begin
      hold_valid_d = 1'b1;
      if (!hold_valid_q) hold_data_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= ZeroWord;
    end else begin
      wb_q         <= wb_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign load_word = hold_valid_q ? hold_data_q : data_sram_rdata;

  load_align u_load_align (
    .mem_ctrl  (wb_q.mem_ctrl),
    .addr      (wb_q.alu[1:0]),
    .word      (load_word),
    .extracted (extracted),
    .misalign  (misalign)
  );

  assign validW    = wb_q.valid;
  assign misalignW = wb_q.valid & misalign;
  assign RegWriteW = wb_q.valid & wb_q.reg_write & ~misalignW;
  assign WriteRegW = wb_q.write_reg;
  assign pcW       = wb_q.pc;
  assign ResultW   = wb_q.mem_to_reg ? extracted : wb_q.alu;

endmodule
